// File: rtl/kyber_pkg.sv
// Shared Kyber512 datapath constants and coefficient-RAM arbiter types.
package kyber_pkg;

   localparam int unsigned KYBER_COEF_W    = 12;
   localparam int unsigned COEFS_PER_WORD  = 4;
   localparam int unsigned COEF_RAM_ADDR_W = 7;
   localparam int unsigned COEF_RAM_DATA_W = KYBER_COEF_W * COEFS_PER_WORD;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      DRAIN = 2'd3
   } arb_state_e;

   typedef logic owner_t;

   localparam owner_t OWNER_M0 = 1'b0;
   localparam owner_t OWNER_M1 = 1'b1;

   typedef struct packed {
      logic   valid;
      owner_t owner;
   } rd_tag_t;

endpackage

// File: rtl/kyber_rd_tag_pipe.sv
// Fixed-depth {valid, owner} delay line matching the coefficient RAM latency.
// clr is synchronous and drops every in-flight tag.
module kyber_rd_tag_pipe
   import kyber_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic    clk,
   input  logic    clr,
   input  rd_tag_t tag_i,
   output rd_tag_t tag_o
);

   rd_tag_t pipe_q [DEPTH];
   rd_tag_t pipe_d [DEPTH];

   always_comb begin
      pipe_d[0] = tag_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (clr) begin
            pipe_q[i] <= '0;
         end else begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/kyber_coef_ram_arbiter.sv
// Round-robin, burst-locked arbiter for the coefficient RAM read port.
// Define COEF_ARB_TIMEOUT_EN to force-release grants held for MAX_HOLD cycles.
module kyber_coef_ram_arbiter
   import kyber_pkg::*;
#(
   parameter int unsigned ADDR_W   = COEF_RAM_ADDR_W,
   parameter int unsigned DATA_W   = COEF_RAM_DATA_W,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned MAX_HOLD = 512
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_rd_en,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_rd_en,
   input  logic [ADDR_W-1:0] m1_addr,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              err_illegal_rd,
   output logic              busy
`ifdef COEF_ARB_TIMEOUT_EN
   ,
   output logic              err_timeout
`endif
);

   localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

   if (RD_LAT < 1 || RD_LAT > 3 || MAX_HOLD < 1) begin : g_bad_cfg
      $error("kyber_coef_ram_arbiter: RD_LAT must be 1..3, MAX_HOLD >= 1");
   end

   arb_state_e        state_q, state_d;
   owner_t            rr_q, rr_d;
   logic [1:0]        drain_cnt_q, drain_cnt_d;
   logic              err_rd_q, err_rd_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

   logic    own0, own1;
   logic    fwd0, fwd1;
   logic    elig0, elig1;
   logic    hold_hit;
   rd_tag_t tag_in, tag_out;

   assign own0 = (state_q == OWN0);
   assign own1 = (state_q == OWN1);
   assign fwd0 = m0_rd_en & m0_req & own0;
   assign fwd1 = m1_rd_en & m1_req & own1;

`ifdef COEF_ARB_TIMEOUT_EN
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              blk0_q, blk0_d;
   logic              blk1_q, blk1_d;
   logic              err_to_q, err_to_d;

   assign hold_hit = (own0 | own1)
                   & (hold_q == HOLD_W'(MAX_HOLD - 1));

   // A timed-out requester yields until it drops req, unless uncontended.
   assign elig0 = m0_req & ~(blk0_q & m1_req);
   assign elig1 = m1_req & ~(blk1_q & m0_req);

   always_comb begin
      hold_d   = (own0 | own1) ? hold_q + 1'b1 : '0;
      blk0_d   = m0_req & (blk0_q | (own0 & hold_hit));
      blk1_d   = m1_req & (blk1_q | (own1 & hold_hit));
      err_to_d = err_to_q | hold_hit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q   <= '0;
         blk0_q   <= 1'b0;
         blk1_q   <= 1'b0;
         err_to_q <= 1'b0;
      end else begin
         hold_q   <= hold_d;
         blk0_q   <= blk0_d;
         blk1_q   <= blk1_d;
         err_to_q <= err_to_d;
      end
   end

   assign err_timeout = err_to_q;
`else
   assign hold_hit = 1'b0;
   assign elig0    = m0_req;
   assign elig1    = m1_req;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_q        <= OWNER_M0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      drain_cnt_d = drain_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (elig0 && (rr_q == OWNER_M0 || !elig1)) begin
               state_d = OWN0;
            end else if (elig1) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            if (!m0_req || hold_hit) begin
               state_d     = DRAIN;
               rr_d        = OWNER_M1;
               drain_cnt_d = '0;
            end
         end
         OWN1: begin
            if (!m1_req || hold_hit) begin
               state_d     = DRAIN;
               rr_d        = OWNER_M0;
               drain_cnt_d = '0;
            end
         end
         DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = IDLE;
            end else begin
               drain_cnt_d = drain_cnt_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tag_in = '{valid: ram_rd_en,
                     owner: own1 ? OWNER_M1 : OWNER_M0};

   kyber_rd_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_tag_pipe (
      .clk   (clk),
      .clr   (~rst_n),
      .tag_i (tag_in),
      .tag_o (tag_out)
   );

   always_comb begin
      m0_gnt     = own0;
      m1_gnt     = own1;
      busy       = (state_q != IDLE);
      ram_rd_en  = fwd0 | fwd1;
      ram_addr_d = ram_addr_q;
      if (own0) begin
         ram_addr_d = m0_addr;
      end else if (own1) begin
         ram_addr_d = m1_addr;
      end
      ram_addr   = ram_addr_d;
      m0_rvalid  = tag_out.valid & (tag_out.owner == OWNER_M0);
      m1_rvalid  = tag_out.valid & (tag_out.owner == OWNER_M1);
      m0_rdata_d = m0_rvalid ? ram_rdata : m0_rdata_q;
      m1_rdata_d = m1_rvalid ? ram_rdata : m1_rdata_q;
      m0_rdata   = m0_rdata_d;
      m1_rdata   = m1_rdata_d;
      err_rd_d   = err_rd_q
                 | (m0_rd_en & ~fwd0)
                 | (m1_rd_en & ~fwd1);
      err_illegal_rd = err_rd_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_rd_q   <= 1'b0;
         ram_addr_q <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         err_rd_q   <= err_rd_d;
         ram_addr_q <= ram_addr_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
      end
   end

endmodule

// File: tb/tb_kyber_coef_ram_arbiter.sv
// Directed bench for kyber_coef_ram_arbiter (RD_LAT=1, RAM word = address).
module tb_kyber_coef_ram_arbiter;

   localparam int AW     = 7;
   localparam int DW     = 48;
   localparam int RD_LAT = 1;
`ifdef COEF_ARB_TIMEOUT_EN
   localparam int MAX_HOLD = 16;
`else
   localparam int MAX_HOLD = 512;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m0_req, m0_rd_en, m1_req, m1_rd_en;
   logic [AW-1:0] m0_addr, m1_addr;
   logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          ram_rd_en;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_rdata = '0;
   logic          err_illegal_rd, busy;
`ifdef COEF_ARB_TIMEOUT_EN
   logic          err_timeout;
`endif

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_rd_en) ram_rdata <= DW'(ram_addr);
   end

   kyber_coef_ram_arbiter #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .RD_LAT   (RD_LAT),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .m0_req         (m0_req),
      .m0_rd_en       (m0_rd_en),
      .m0_addr        (m0_addr),
      .m0_gnt         (m0_gnt),
      .m0_rvalid      (m0_rvalid),
      .m0_rdata       (m0_rdata),
      .m1_req         (m1_req),
      .m1_rd_en       (m1_rd_en),
      .m1_addr        (m1_addr),
      .m1_gnt         (m1_gnt),
      .m1_rvalid      (m1_rvalid),
      .m1_rdata       (m1_rdata),
      .ram_rd_en      (ram_rd_en),
      .ram_addr       (ram_addr),
      .ram_rdata      (ram_rdata),
      .err_illegal_rd (err_illegal_rd),
      .busy           (busy)
`ifdef COEF_ARB_TIMEOUT_EN
      ,
      .err_timeout    (err_timeout)
`endif
   );

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int rv_cnt;
      int bad;
      int other;
      logic own;
      logic [AW-1:0] a;

      rst_n = 0;
      m0_req = 0; m0_rd_en = 0; m0_addr = '0;
      m1_req = 0; m1_rd_en = 0; m1_addr = '0;
      tick();
      tick();
      chk("rst_m0_gnt",  64'(m0_gnt), 64'(0));
      chk("rst_m1_gnt",  64'(m1_gnt), 64'(0));
      chk("rst_busy",    64'(busy), 64'(0));
      chk("rst_ram_en",  64'(ram_rd_en), 64'(0));
      chk("rst_ram_adr", 64'(ram_addr), 64'(0));
      chk("rst_err",     64'(err_illegal_rd), 64'(0));
      chk("rst_rvalid",  64'({m0_rvalid, m1_rvalid}), 64'(0));
      chk("rst_rdata",   64'(m0_rdata | m1_rdata), 64'(0));
      rst_n = 1;

      // single m0 burst, addresses 63 down to 0
      m0_req = 1;
      tick();
      chk("burst_gnt0", 64'(m0_gnt), 64'(1));
      chk("burst_gnt1", 64'(m1_gnt), 64'(0));
      chk("burst_busy", 64'(busy), 64'(1));
      rv_cnt = 0; bad = 0; other = 0;
      for (int i = 0; i < 64; i++) begin
         m0_rd_en = 1;
         m0_addr  = AW'(63 - i);
         tick();
         rv_cnt += int'(m0_rvalid);
         if (!(m0_rvalid && m0_rdata === DW'(63 - i))) bad++;
         other += int'(m1_rvalid);
      end
      m0_rd_en = 0;
      chk("burst_rv_cnt", 64'(rv_cnt), 64'(64));
      chk("burst_data",   64'(bad), 64'(0));
      chk("burst_m1_rv",  64'(other), 64'(0));
      m0_req = 0;
      tick();
      chk("burst_rel_gnt",  64'(m0_gnt), 64'(0));
      chk("burst_drain",    64'(busy), 64'(1));
      tick();
      chk("burst_idle",     64'(busy), 64'(0));
      chk("burst_no_extra", 64'(m0_rvalid), 64'(0));

      // contention from reset: grants must alternate m0, m1, m0, m1
      rst_n = 0;
      tick();
      rst_n = 1;
      m0_req = 1;
      m1_req = 1;
      for (int r = 0; r < 4; r++) begin
         n = 0;
         while (!(m0_gnt || m1_gnt) && n < 12) begin
            tick();
            n++;
         end
         chk($sformatf("cont_gnt_r%0d", r), 64'(m0_gnt | m1_gnt), 64'(1));
         chk($sformatf("cont_order_r%0d", r), 64'(m1_gnt), 64'(r % 2));
         if (r > 0) chk($sformatf("cont_gap_r%0d", r), 64'(n), 64'(RD_LAT + 1));
         own = m1_gnt;
         rv_cnt = 0; bad = 0; other = 0;
         for (int j = 0; j < 8; j++) begin
            a = AW'(8 * r + j);
            if (own) begin
               m1_rd_en = 1; m1_addr = a;
            end else begin
               m0_rd_en = 1; m0_addr = a;
            end
            tick();
            if (own) begin
               rv_cnt += int'(m1_rvalid);
               if (!(m1_rvalid && m1_rdata === DW'(a))) bad++;
               other += int'(m0_rvalid);
            end else begin
               rv_cnt += int'(m0_rvalid);
               if (!(m0_rvalid && m0_rdata === DW'(a))) bad++;
               other += int'(m1_rvalid);
            end
         end
         m0_rd_en = 0;
         m1_rd_en = 0;
         chk($sformatf("cont_rv_r%0d", r), 64'(rv_cnt), 64'(8));
         chk($sformatf("cont_data_r%0d", r), 64'(bad), 64'(0));
         chk($sformatf("cont_other_r%0d", r), 64'(other), 64'(0));
         if (own) m1_req = 0;
         else     m0_req = 0;
         tick();
         chk($sformatf("cont_rel_r%0d", r), 64'(m0_gnt | m1_gnt), 64'(0));
         if (r < 3) begin
            if (own) m1_req = 1;
            else     m0_req = 1;
         end
      end
      m0_req = 0;
      m1_req = 0;
      tick();
      tick();
      chk("cont_idle",   64'(busy), 64'(0));
      chk("cont_no_err", 64'(err_illegal_rd), 64'(0));

      // m1 releases in the same cycle as a strobe to addr 5
      m1_req = 1;
      tick();
      chk("rel_gnt1", 64'(m1_gnt), 64'(1));
      m1_rd_en = 1;
      m1_addr  = 7'd4;
      #1;
      chk("rel_fwd4", 64'(ram_rd_en), 64'(1));
      tick();
      chk("rel_rv4",   64'(m1_rvalid), 64'(1));
      chk("rel_data4", 64'(m1_rdata), 64'(4));
      m1_req  = 0;
      m1_addr = 7'd5;
      #1;
      chk("rel_drop5", 64'(ram_rd_en), 64'(0));
      tick();
      m1_rd_en = 0;
      chk("rel_no_rv5", 64'(m1_rvalid), 64'(0));
      chk("rel_hold4",  64'(m1_rdata), 64'(4));
      chk("rel_err",    64'(err_illegal_rd), 64'(1));
      chk("rel_gnt_dn", 64'(m1_gnt), 64'(0));
      tick();
      tick();

      // m1 strobes while m0 owns the port
      rst_n = 0;
      tick();
      rst_n = 1;
      chk("ill_err_clr", 64'(err_illegal_rd), 64'(0));
      m0_req = 1;
      tick();
      chk("ill_gnt0", 64'(m0_gnt), 64'(1));
      m0_rd_en = 1; m0_addr = 7'd10;
      m1_rd_en = 1; m1_addr = 7'd99;
      #1;
      chk("ill_addr", 64'(ram_addr), 64'(10));
      chk("ill_fwd",  64'(ram_rd_en), 64'(1));
      tick();
      m0_rd_en = 0;
      m1_rd_en = 0;
      chk("ill_err",   64'(err_illegal_rd), 64'(1));
      chk("ill_rv0",   64'(m0_rvalid), 64'(1));
      chk("ill_data0", 64'(m0_rdata), 64'(10));
      chk("ill_rv1",   64'(m1_rvalid), 64'(0));
      m0_req = 0;
      tick();
      tick();
      tick();
      chk("ill_sticky", 64'(err_illegal_rd), 64'(1));
      chk("ill_idle",   64'(busy), 64'(0));

      // reset with one read in flight
      m0_req = 1;
      tick();
      chk("rmb_gnt0", 64'(m0_gnt), 64'(1));
      m0_rd_en = 1;
      m0_addr  = 7'd20;
      rst_n    = 0;
      #1;
      chk("rmb_fwd", 64'(ram_rd_en), 64'(1));
      tick();
      chk("rmb_rv",    64'({m0_rvalid, m1_rvalid}), 64'(0));
      chk("rmb_gnt",   64'({m0_gnt, m1_gnt}), 64'(0));
      chk("rmb_busy",  64'(busy), 64'(0));
      chk("rmb_addr",  64'(ram_addr), 64'(0));
      chk("rmb_rdata", 64'(m0_rdata | m1_rdata), 64'(0));
      chk("rmb_err",   64'(err_illegal_rd), 64'(0));
      rst_n    = 1;
      m0_rd_en = 0;
      m0_req   = 0;
      tick();
      chk("rmb_rv2",   64'({m0_rvalid, m1_rvalid}), 64'(0));
      chk("rmb_ren",   64'(ram_rd_en), 64'(0));

`ifdef COEF_ARB_TIMEOUT_EN
      // m0 hogs the port while m1 waits
      rst_n = 0;
      tick();
      rst_n = 1;
      m0_req = 1;
      m1_req = 1;
      tick();
      chk("to_gnt0", 64'(m0_gnt), 64'(1));
      n = 0;
      while (m0_gnt && n < 40) begin
         tick();
         n++;
      end
      chk("to_hold", 64'(n), 64'(MAX_HOLD));
      chk("to_err",  64'(err_timeout), 64'(1));
      n = 0;
      while (!m1_gnt && n < 12) begin
         tick();
         n++;
      end
      chk("to_gap",  64'(n), 64'(RD_LAT + 1));
      chk("to_gnt1", 64'(m1_gnt), 64'(1));
      m0_req = 0;
      m1_req = 0;
      tick();
      tick();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
